// File: rtl/simd_ctrl_pkg.sv
// Shared types and instruction-field layout for the SIMD control sequencer.
package simd_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_CLR   = 3'd1,
        OP_LOADA = 3'd2,
        OP_LOADB = 3'd3,
        OP_MAC   = 3'd4,
        OP_STORE = 3'd5,
        OP_HALT  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_LOADA,
        S_LOADB,
        S_MAC,
        S_STORE,
        S_HALT,
        S_ERROR
    } state_e;

    localparam int OP_LSB      = 0;
    localparam int DIMEN_LSB   = 3;
    localparam int CLR_BIT     = 5;
    localparam int MASK_LSB    = 8;
    localparam int ADDR_LSB    = 16;
    localparam int RPT_LSB     = 24;
    localparam int INSTR_MIN_W = 29;

    typedef struct packed {
        logic [4:0] rpt;
        logic [7:0] addr;
        logic [7:0] mask;
        logic       clr_acc;
        logic [1:0] dimen;
        op_e        op;
    } instr_t;

    // Pull the fixed-position fields out of the raw instruction word.
    function automatic instr_t decode_instr(input logic [INSTR_MIN_W-1:0] raw);
        instr_t d;
        d.op      = op_e'(raw[OP_LSB +: 3]);
        d.dimen   = raw[DIMEN_LSB +: 2];
        d.clr_acc = raw[CLR_BIT];
        d.mask    = raw[MASK_LSB +: 8];
        d.addr    = raw[ADDR_LSB +: 8];
        d.rpt     = raw[RPT_LSB +: 5];
        return d;
    endfunction

    // A repeat count of zero still performs one MAC step.
    function automatic logic [4:0] rep_init(input logic [4:0] r);
        return (r == 5'd0) ? 5'd1 : r;
    endfunction

endpackage

// File: rtl/simd_ctrl_fsm_watchdog.sv
// Per-instruction cycle watchdog: counts cycles spent in an execute state and
// flags expiry on the cycle whose edge would bring the count to TIMEOUT.
module simd_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt;

    // Count execute-state cycles; clear restarts the window.
    always_ff @(posedge CLK) begin
        if (!RSTN || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && run && (cnt == LAST);

endmodule

// File: rtl/simd_ctrl_fsm.sv
// Instruction sequencer for the N-lane SIMD array: fetch handshake, load/MAC/
// store sequencing with lane masks, and a per-instruction watchdog.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for START_SIGNAL
// S_DECODE | waiting for INSTR_VALID; NOP/CLR retire here
// S_LOADA  | loading A operand until FETCH_DONE
// S_LOADB  | loading B operand until FETCH_DONE
// S_MAC    | issuing rep_cnt MAC steps, one per MAC_DONE
// S_STORE  | storing results until STORE_DONE
// S_HALT   | stopped until reset
// S_ERROR  | watchdog expiry or reserved opcode, sticky until reset
module simd_ctrl_fsm
    import simd_ctrl_pkg::*;
#(
    parameter int N_PE    = 4,
    parameter int ADDR_W  = 4,
    parameter int DIMEN_W = 2,
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               START_SIGNAL,
    input  logic [INSTR_W-1:0] INSTR,
    input  logic               INSTR_VALID,
    output logic               PC_INCR,
    output logic               INSTR_DONE,
    output logic               BUSY,
    output logic [N_PE-1:0]    RST_ACC,
    output logic [N_PE-1:0]    RST_ADD,
    output logic [N_PE-1:0]    WRITE_MAT,
    output logic               MAT_MUX,
    output logic [N_PE-1:0]    MAC_CTRL,
    input  logic               MAC_DONE,
    output logic [N_PE-1:0]    OUT_READY,
    output logic [DIMEN_W-1:0] DIMEN,
    output logic               ADDR_START,
    output logic               ADDR_RST,
    output logic [ADDR_W-1:0]  ADDRESS,
    input  logic               FETCH_DONE,
    output logic               WRADDR_START,
    input  logic               STORE_DONE,
    output logic               STOP_SIGNAL,
    output logic               ERROR
);

    state_e             state;
    instr_t             instr_q;
    logic [4:0]         rep_cnt;
    instr_t             in_d;
    logic [N_PE-1:0]    in_mask, q_mask;
    logic [ADDR_W-1:0]  in_addr, q_addr;
    logic [DIMEN_W-1:0] in_dimen, q_dimen;
    logic               wd_clr, wd_run, wd_expired;
    logic               unused_bits;

    assign in_d     = decode_instr(INSTR[INSTR_MIN_W-1:0]);
    assign in_mask  = in_d.mask[N_PE-1:0];
    assign in_addr  = in_d.addr[ADDR_W-1:0];
    assign in_dimen = DIMEN_W'(in_d.dimen);
    assign q_mask   = instr_q.mask[N_PE-1:0];
    assign q_addr   = instr_q.addr[ADDR_W-1:0];
    assign q_dimen  = DIMEN_W'(instr_q.dimen);

    assign unused_bits = ^{INSTR, instr_q};

    // Watchdog window restarts on instruction accept and on every MAC step.
    assign wd_run = (state == S_LOADA) || (state == S_LOADB) ||
                    (state == S_MAC)   || (state == S_STORE);
    assign wd_clr = ((state == S_DECODE) && INSTR_VALID) ||
                    ((state == S_MAC) && MAC_DONE);

    simd_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .clr     (wd_clr),
        .run     (wd_run),
        .expired (wd_expired)
    );

    // Sequencer state and all registered strobes; completion beats watchdog.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state        <= S_IDLE;
            instr_q      <= '0;
            rep_cnt      <= '0;
            PC_INCR      <= 1'b0;
            INSTR_DONE   <= 1'b0;
            BUSY         <= 1'b0;
            RST_ACC      <= '1;
            RST_ADD      <= '1;
            WRITE_MAT    <= '0;
            MAT_MUX      <= 1'b0;
            MAC_CTRL     <= '0;
            OUT_READY    <= '0;
            DIMEN        <= '0;
            ADDR_START   <= 1'b0;
            ADDR_RST     <= 1'b1;
            ADDRESS      <= '0;
            WRADDR_START <= 1'b0;
            STOP_SIGNAL  <= 1'b0;
            ERROR        <= 1'b0;
        end else begin
            PC_INCR      <= 1'b0;
            INSTR_DONE   <= 1'b0;
            BUSY         <= 1'b1;
            RST_ACC      <= '0;
            RST_ADD      <= '0;
            WRITE_MAT    <= '0;
            MAT_MUX      <= 1'b0;
            MAC_CTRL     <= '0;
            OUT_READY    <= '0;
            DIMEN        <= '0;
            ADDR_START   <= 1'b0;
            ADDR_RST     <= 1'b0;
            ADDRESS      <= '0;
            WRADDR_START <= 1'b0;
            STOP_SIGNAL  <= 1'b0;
            ERROR        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START_SIGNAL) state <= S_DECODE;
                    else              BUSY  <= 1'b0;
                end
                S_DECODE: begin
                    if (INSTR_VALID) begin
                        instr_q <= in_d;
                        PC_INCR <= 1'b1;
                        DIMEN   <= in_dimen;
                        if (in_d.clr_acc) RST_ACC <= in_mask;
                        case (in_d.op)
                            OP_NOP: INSTR_DONE <= 1'b1;
                            OP_CLR: begin
                                INSTR_DONE <= 1'b1;
                                RST_ACC    <= in_mask;
                            end
                            OP_LOADA, OP_LOADB: begin
                                state      <= (in_d.op == OP_LOADA) ? S_LOADA : S_LOADB;
                                WRITE_MAT  <= in_mask;
                                MAT_MUX    <= (in_d.op == OP_LOADA);
                                ADDRESS    <= in_addr;
                                ADDR_START <= 1'b1;
                            end
                            OP_MAC: begin
                                state   <= S_MAC;
                                rep_cnt <= rep_init(in_d.rpt);
                            end
                            OP_STORE: begin
                                state        <= S_STORE;
                                OUT_READY    <= in_mask;
                                WRADDR_START <= 1'b1;
                                ADDR_START   <= 1'b1;
                                ADDRESS      <= in_addr;
                            end
                            OP_HALT: begin
                                state       <= S_HALT;
                                STOP_SIGNAL <= 1'b1;
                                BUSY        <= 1'b0;
                            end
                            default: begin
                                state    <= S_ERROR;
                                ERROR    <= 1'b1;
                                ADDR_RST <= 1'b1;
                                RST_ACC  <= '0;
                                BUSY     <= 1'b0;
                            end
                        endcase
                    end
                end
                S_LOADA, S_LOADB: begin
                    if (FETCH_DONE) begin
                        state      <= S_DECODE;
                        ADDR_RST   <= 1'b1;
                        RST_ADD    <= q_mask;
                        INSTR_DONE <= 1'b1;
                    end else if (wd_expired) begin
                        state    <= S_ERROR;
                        ERROR    <= 1'b1;
                        ADDR_RST <= 1'b1;
                        BUSY     <= 1'b0;
                    end else begin
                        WRITE_MAT  <= q_mask;
                        MAT_MUX    <= (state == S_LOADA);
                        ADDRESS    <= q_addr;
                        DIMEN      <= q_dimen;
                        ADDR_START <= 1'b1;
                    end
                end
                S_MAC: begin
                    if (MAC_DONE) begin
                        MAC_CTRL <= q_mask;
                        rep_cnt  <= rep_cnt - 5'd1;
                        if (rep_cnt == 5'd1) begin
                            state      <= S_DECODE;
                            INSTR_DONE <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        state    <= S_ERROR;
                        ERROR    <= 1'b1;
                        ADDR_RST <= 1'b1;
                        BUSY     <= 1'b0;
                    end
                end
                S_STORE: begin
                    if (STORE_DONE) begin
                        state      <= S_DECODE;
                        ADDR_RST   <= 1'b1;
                        INSTR_DONE <= 1'b1;
                    end else if (wd_expired) begin
                        state    <= S_ERROR;
                        ERROR    <= 1'b1;
                        ADDR_RST <= 1'b1;
                        BUSY     <= 1'b0;
                    end else begin
                        OUT_READY    <= q_mask;
                        WRADDR_START <= 1'b1;
                        ADDR_START   <= 1'b1;
                        ADDRESS      <= q_addr;
                        DIMEN        <= q_dimen;
                    end
                end
                S_HALT: begin
                    STOP_SIGNAL <= 1'b1;
                    BUSY        <= 1'b0;
                end
                default: begin
                    ERROR    <= 1'b1;
                    ADDR_RST <= 1'b1;
                    BUSY     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/simd_ctrl_fsm.md
Name: simd_ctrl_fsm

Overview:
Parametrised instruction sequencer for the N-lane SIMD array. It replaces the fixed 4-PE control unit with generic lane masks, a fetch-side valid handshake, a MAC repeat count, and a per-instruction watchdog. It sits between the instruction fetch (PC) and the PE array / data-fetch address generators, and drives all PE, load and store strobes from registered outputs.

Parameters:
N_PE, 4, number of PE lanes (1..8)
ADDR_W, 4, data-memory base address width (1..8)
DIMEN_W, 2, matrix dimension code width
INSTR_W, 32, instruction width (fixed format below, >=29)
TIMEOUT, 255, max cycles in an execute state before ERROR; 0 disables the watchdog

Ports:
CLK  in  1  clock
RSTN  in  1  reset, synchronous, active-low
START_SIGNAL  in  1  GPIO start; IDLE->DECODE
INSTR  in  INSTR_W  instruction from fetch
INSTR_VALID  in  1  INSTR is valid this cycle
PC_INCR  out  1  1-cycle pulse: instruction accepted, advance PC
INSTR_DONE  out  1  1-cycle pulse: instruction retired
BUSY  out  1  high in any state other than IDLE/HALT/ERROR
RST_ACC  out  N_PE  accumulator clear per lane
RST_ADD  out  N_PE  PE load-address counter reset per lane
WRITE_MAT  out  N_PE  matrix-write enable per lane
MAT_MUX  out  1  1 = A operand, 0 = B operand
MAC_CTRL  out  N_PE  MAC step per lane
MAC_DONE  in  1  MAC step complete
OUT_READY  out  N_PE  lanes presenting results for store
DIMEN  out  DIMEN_W  dimension code of the current instruction
ADDR_START  out  1  run the data-fetch address generator
ADDR_RST  out  1  reset the address generator
ADDRESS  out  ADDR_W  base address
FETCH_DONE  in  1  load transfer complete
WRADDR_START  out  1  run the store address generator
STORE_DONE  in  1  store transfer complete
STOP_SIGNAL  out  1  high in HALT
ERROR  out  1  high in ERROR (sticky)

Behaviour:
- Instruction format: [2:0] op (0 NOP, 1 CLR, 2 LOADA, 3 LOADB, 4 MAC, 5 STORE, 6 HALT, 7 reserved -> ERROR); [4:3] dimen; [5] clr_acc; [15:8] lane mask (low N_PE bits used); [23:16] address (low ADDR_W bits used); [28:24] repeat count (MAC only; 0 is treated as 1).
- All outputs are registered. Default each cycle: 0, except as noted below.
- Reset (RSTN=0 at the edge): state=IDLE, RST_ACC=RST_ADD=all ones, ADDR_RST=1, all other outputs 0, counters 0. Applies mid-operation too; there is no pending state after reset.
- IDLE: outputs at default. Go to DECODE on the edge where START_SIGNAL=1.
- DECODE: wait for INSTR_VALID. On the accept edge: latch INSTR into instr_q, assert PC_INCR, drive DIMEN, and set RST_ACC=mask if clr_acc=1. Next state by op:
  - NOP and CLR: retire in the accept cycle (INSTR_DONE=1) and stay in DECODE. CLR sets RST_ACC=mask regardless of clr_acc.
  - Other ops go to their execute state.
- LOADA/LOADB: each cycle drive WRITE_MAT=mask, MAT_MUX=1 (A) or 0 (B), ADDRESS, DIMEN, and ADDR_START=1. On FETCH_DONE: ADDR_START=0, ADDR_RST=1, RST_ADD=mask, INSTR_DONE=1, go to DECODE.
- MAC: on entry, rep_cnt = max(repeat, 1). For each cycle with MAC_DONE=1: MAC_CTRL=mask for one cycle, decrement rep_cnt, and restart the watchdog. When the decrement takes rep_cnt to 0: INSTR_DONE=1, go to DECODE.
- STORE: each cycle drive OUT_READY=mask, WRADDR_START=1, ADDR_START=1, ADDRESS, DIMEN. On STORE_DONE: ADDR_RST=1, ADDR_START=0, INSTR_DONE=1, go to DECODE.
- HALT: STOP_SIGNAL=1. Sticky until reset; START_SIGNAL is ignored.
- Watchdog: cycle counter cleared on entry to each execute state and on each MAC_DONE. If it reaches TIMEOUT before the completion input arrives: go to ERROR (ERROR=1, ADDR_RST=1, all lane strobes 0). ERROR is sticky until reset.
- Completion input and timeout in the same cycle: completion wins.
- FETCH_DONE, STORE_DONE and MAC_DONE are ignored outside their own state.
- INSTR_VALID is ignored outside DECODE.
- Mask 0 is legal: the handshake still runs and no lane strobes fire.

Decomposition:
- Package simd_ctrl_pkg: opcode enum op_e, state enum state_e, instruction field bit-position localparams, and an instr_t packed struct for decoding.
- One sub-module: simd_watchdog (load/clear, count, expire flag; parameter TIMEOUT).

Test Plan:
- Reset, START_SIGNAL=1, LOADA with mask=4'b0101, addr=3, FETCH_DONE after 5 cycles -> WRITE_MAT=0101, MAT_MUX=1 and ADDR_START=1 for 5 cycles; then ADDR_RST=1, RST_ADD=0101, a single INSTR_DONE pulse, back to DECODE.
- MAC with repeat=3, mask=1111, three MAC_DONE pulses -> exactly three MAC_CTRL=1111 pulses; INSTR_DONE coincides with the third; repeat=0 gives one pulse.
- STORE with mask=1100, STORE_DONE after 8 cycles -> OUT_READY=1100 and WRADDR_START=1 for 8 cycles, then INSTR_DONE.
- TIMEOUT=10, LOADB with FETCH_DONE never asserted -> ERROR=1 on cycle 10, strobes 0; a later FETCH_DONE is ignored; only RSTN=0 clears ERROR.
- Sequence CLR(mask=0011), NOP, HALT -> RST_ACC=0011 for one cycle, three PC_INCR pulses, STOP_SIGNAL=1 held; opcode 7 -> ERROR.
- RSTN=0 in the middle of MAC -> next edge: IDLE, RST_ACC=all ones, MAC_CTRL=0, BUSY=0.
